// File: rtl/rr_bus_arbiter_wdt_pkg.sv
// Shared definitions for the round-robin bus arbiter with watchdog:
// FSM state encoding and a width helper used for index/counter sizing.
package rr_bus_arbiter_wdt_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // ceil(log2(value)), never less than 1 so single-entry vectors stay legal
  function automatic int clog2_min1(input int value);
    int width;
    width = 0;
    while ((1 << width) < value) begin
      width = width + 1;
    end
    return (width < 1) ? 1 : width;
  endfunction

endpackage

// File: rtl/rr_bus_arbiter_wdt_if.sv
// Bus bundle between NMASTERS masters, the arbiter and the single slave.
// The arbiter modport is the arbiter's own view; master/slave are the attached agents.
interface rr_bus_arbiter_wdt_if #(
  parameter int NMASTERS = 2
);

  logic [32*NMASTERS-1:0] master_address;
  logic [32*NMASTERS-1:0] master_data_i;
  logic [4*NMASTERS-1:0]  master_wr;
  logic [NMASTERS-1:0]    master_enable;
  logic [31:0]            master_data_o;
  logic [NMASTERS-1:0]    master_ready;
  logic [NMASTERS-1:0]    master_error;
  logic [31:0]            slave_data_i;
  logic                   slave_ready;
  logic                   slave_error;
  logic [31:0]            slave_address;
  logic [31:0]            slave_data_o;
  logic [3:0]             slave_wr;
  logic                   slave_enable;

  modport arbiter (
    input  master_address, master_data_i, master_wr, master_enable,
    input  slave_data_i, slave_ready, slave_error,
    output master_data_o, master_ready, master_error,
    output slave_address, slave_data_o, slave_wr, slave_enable
  );

  modport master (
    output master_address, master_data_i, master_wr, master_enable,
    input  master_data_o, master_ready, master_error
  );

  modport slave (
    output slave_data_i, slave_ready, slave_error,
    input  slave_address, slave_data_o, slave_wr, slave_enable
  );

endinterface

// File: rtl/rr_bus_arbiter_wdt_priority_picker.sv
// Combinational round-robin picker: finds the first set request starting just
// after the last granted index, wrapping modulo N.
module rr_priority_picker #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          found,
  output logic [IW-1:0] next
);

  // Rotate so the search starts at last+1, find the first hit, then map it back
  always_comb begin
    logic [N-1:0] rot_s;
    int           start_s;
    int           hit_s;
    int           idx_s;

    rot_s   = '0;
    hit_s   = 0;
    idx_s   = 0;
    start_s = int'(last) + 1;
    if (start_s >= N) begin
      start_s = 0;
    end else begin
      start_s = start_s;
    end

    for (int k = 0; k < N; k++) begin
      idx_s = start_s + k;
      if (idx_s >= N) begin
        idx_s = idx_s - N;
      end else begin
        idx_s = idx_s;
      end
      rot_s[k] = req[idx_s];
    end

    for (int k = N - 1; k >= 0; k--) begin
      if (rot_s[k]) begin
        hit_s = k;
      end else begin
        hit_s = hit_s;
      end
    end

    idx_s = start_s + hit_s;
    if (idx_s >= N) begin
      idx_s = idx_s - N;
    end else begin
      idx_s = idx_s;
    end

    found = |rot_s;
    next  = IW'(idx_s);
  end

endmodule

// File: rtl/rr_bus_arbiter_wdt.sv
// Round-robin arbiter sharing one slave among NMASTERS masters, with a bus
// watchdog that errors the owner and frees the bus if the slave never answers.
module rr_bus_arbiter_wdt
  import rr_bus_arbiter_wdt_pkg::*;
#(
  parameter int NMASTERS = 2,
  parameter int TIMEOUT  = 255
) (
  input  logic                                  clk,
  input  logic                                  rst,
  rr_bus_arbiter_wdt_if.arbiter                 bus,
  output logic                                  timeout_pulse,
  output logic [clog2_min1(NMASTERS)-1:0]       timeout_master
);

  localparam int IW = clog2_min1(NMASTERS);
  localparam int CW = clog2_min1(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam bit WDT_ON = (TIMEOUT != 0);

  arb_state_t          state_r, state_n;
  logic [IW-1:0]       owner_r, owner_n;
  logic [IW-1:0]       last_r, last_n;
  logic [CW-1:0]       count_r, count_n;
  logic                timeout_pulse_r;
  logic [IW-1:0]       timeout_master_r;

  logic                found_s;
  logic [IW-1:0]       pick_s;
  logic                owner_en_s;
  logic                enable_s;
  logic                expire_s;
  logic [NMASTERS-1:0] ready_s;
  logic [NMASTERS-1:0] error_s;

  rr_priority_picker #(
    .N  (NMASTERS),
    .IW (IW)
  ) u_picker (
    .req   (bus.master_enable),
    .last  (last_r),
    .found (found_s),
    .next  (pick_s)
  );

  assign owner_en_s = bus.master_enable[owner_r];

  // Next-state and per-cycle handshake outputs; abort beats error beats ready beats watchdog
  always_comb begin
    state_n  = state_r;
    owner_n  = owner_r;
    last_n   = last_r;
    count_n  = count_r;
    ready_s  = '0;
    error_s  = '0;
    enable_s = 1'b0;
    expire_s = 1'b0;

    case (state_r)
      IDLE: begin
        if (found_s) begin
          owner_n = pick_s;
          last_n  = pick_s;
          count_n = '0;
          state_n = BUSY;
        end else begin
          state_n = IDLE;
        end
      end
      BUSY: begin
        if (WDT_ON) begin
          count_n = count_r + CW'(1);
        end else begin
          count_n = count_r;
        end
        if (!owner_en_s) begin
          state_n = IDLE;
        end else if (bus.slave_error) begin
          error_s[owner_r] = 1'b1;
          enable_s         = 1'b1;
          state_n          = IDLE;
        end else if (bus.slave_ready) begin
          ready_s[owner_r] = 1'b1;
          enable_s         = 1'b1;
          state_n          = IDLE;
        end else if (WDT_ON && (count_r == LIMIT)) begin
          error_s[owner_r] = 1'b1;
          expire_s         = 1'b1;
          state_n          = IDLE;
        end else begin
          enable_s = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, grant bookkeeping and watchdog report registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= IDLE;
      owner_r          <= '0;
      last_r           <= IW'(NMASTERS - 1);
      count_r          <= '0;
      timeout_pulse_r  <= 1'b0;
      timeout_master_r <= '0;
    end else begin
      state_r         <= state_n;
      owner_r         <= owner_n;
      last_r          <= last_n;
      count_r         <= count_n;
      timeout_pulse_r <= expire_s;
      if (expire_s) begin
        timeout_master_r <= owner_r;
      end
    end
  end

  assign bus.master_data_o = bus.slave_data_i;
  assign bus.master_ready  = ready_s;
  assign bus.master_error  = error_s;
  assign bus.slave_address = bus.master_address[32*owner_r +: 32];
  assign bus.slave_data_o  = bus.master_data_i[32*owner_r +: 32];
  assign bus.slave_wr      = bus.master_wr[4*owner_r +: 4];
  assign bus.slave_enable  = enable_s;
  assign timeout_pulse     = timeout_pulse_r;
  assign timeout_master    = timeout_master_r;

endmodule
